// File: rtl/xmem_arb_pkg.sv
// Shared types and defaults for the xmem_arbiter register-bank arbiter.
// The optional XMEM_ARB_STATS_EN statistics build uses sat_inc16.
package xmem_arb_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_NEED,
      PF_BUSY,
      PF_VALID
   } pf_state_t;

   typedef enum logic {
      SIDE_HOST,
      SIDE_LOC
   } arb_side_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/xmem_arb_ram.sv
// Single-port synchronous RAM: one read or write per enabled cycle, 1-cycle read latency.
module xmem_arb_ram #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/xmem_arbiter.sv
// Arbitrates a register bank between the Xillybus mem_32 host stream and one local requester.
// Optional grant/conflict statistics are enabled with `define XMEM_ARB_STATS_EN.
module xmem_arbiter
   import xmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              bus_clk,
   input  logic              trn_reset_n,
   input  logic              user_w_mem_32_wren,
   input  logic [DATA_W-1:0] user_w_mem_32_data,
   output logic              user_w_mem_32_full,
   input  logic              user_w_mem_32_open,
   input  logic              user_r_mem_32_rden,
   output logic [DATA_W-1:0] user_r_mem_32_data,
   output logic              user_r_mem_32_empty,
   output logic              user_r_mem_32_eof,
   input  logic              user_r_mem_32_open,
   input  logic [ADDR_W-1:0] user_mem_32_addr,
   input  logic              user_mem_32_addr_update,
   input  logic              loc_req,
   input  logic              loc_we,
   input  logic [ADDR_W-1:0] loc_addr,
   input  logic [DATA_W-1:0] loc_wdata,
   output logic              loc_gnt,
   output logic              loc_rvalid,
   output logic [DATA_W-1:0] loc_rdata,
   output pf_state_t         pf_state_dbg
`ifdef XMEM_ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [15:0]       stat_host_grants,
   output logic [15:0]       stat_loc_grants,
   output logic [15:0]       stat_conflicts
`endif
);

   logic              arb_en;
   logic              wbuf_valid;
   logic [ADDR_W-1:0] wbuf_addr;
   logic [DATA_W-1:0] wbuf_data;
   pf_state_t         pf_state;
   logic [ADDR_W-1:0] pf_addr;
   arb_side_t         last_side;

   logic              host_rd_req;
   logic              host_req;
   logic              gnt_host;
   logic              gnt_loc;
   logic              host_wr_gnt;
   logic              host_rd_gnt;
   logic              wr_hit_pf;
   logic              wbuf_load;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Valid/ready contract: the host may pulse wren only while full=0; the local side
   // holds loc_req with a stable command until the cycle loc_gnt is high.
   always_comb begin
      host_rd_req = (pf_state == PF_NEED) & user_r_mem_32_open & ~wbuf_valid;
      host_req    = wbuf_valid | host_rd_req;
      gnt_host    = arb_en & host_req & (~loc_req | (last_side == SIDE_LOC));
      gnt_loc     = arb_en & loc_req & ~gnt_host;
      host_wr_gnt = gnt_host & wbuf_valid;
      host_rd_gnt = gnt_host & ~wbuf_valid;
      wr_hit_pf   = (host_wr_gnt & (wbuf_addr == pf_addr)) |
                    (gnt_loc & loc_we & (loc_addr == pf_addr));
      wbuf_load   = user_w_mem_32_wren & user_w_mem_32_open & ~user_w_mem_32_full;

      ram_en    = gnt_host | gnt_loc;
      ram_we    = host_wr_gnt | (gnt_loc & loc_we);
      ram_addr  = loc_addr;
      ram_wdata = loc_wdata;
      if (gnt_host) begin
         ram_addr  = wbuf_valid ? wbuf_addr : user_mem_32_addr;
         ram_wdata = wbuf_data;
      end
   end

   assign user_w_mem_32_full  = wbuf_valid & ~host_wr_gnt;
   assign user_r_mem_32_empty = (pf_state != PF_VALID);
   assign user_r_mem_32_eof   = 1'b0;
   assign loc_gnt             = gnt_loc;
   assign loc_rdata           = loc_rvalid ? ram_rdata : '0;
   assign pf_state_dbg        = pf_state;

   xmem_arb_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (bus_clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // arb_en holds off grants until the first edge after reset release.
   always_ff @(posedge bus_clk or negedge trn_reset_n) begin
      if (!trn_reset_n) begin
         arb_en             <= 1'b0;
         wbuf_valid         <= 1'b0;
         wbuf_addr          <= '0;
         wbuf_data          <= '0;
         last_side          <= SIDE_LOC;
         loc_rvalid         <= 1'b0;
         pf_state           <= PF_IDLE;
         pf_addr            <= '0;
         user_r_mem_32_data <= '0;
      end else begin
         arb_en     <= 1'b1;
         loc_rvalid <= gnt_loc & ~loc_we;

         if (wbuf_load) begin
            wbuf_valid <= 1'b1;
            wbuf_addr  <= user_mem_32_addr;
            wbuf_data  <= user_w_mem_32_data;
         end else if (host_wr_gnt) begin
            wbuf_valid <= 1'b0;
         end

         if (gnt_host)     last_side <= SIDE_HOST;
         else if (gnt_loc) last_side <= SIDE_LOC;

         if (!user_r_mem_32_open) begin
            pf_state <= PF_IDLE;
         end else begin
            case (pf_state)
               PF_IDLE: pf_state <= PF_NEED;
               PF_NEED: begin
                  if (host_rd_gnt) begin
                     pf_addr  <= user_mem_32_addr;
                     pf_state <= PF_BUSY;
                  end
               end
               PF_BUSY: begin
                  // A seek or overlapping write makes the in-flight word stale.
                  if (user_mem_32_addr_update | wr_hit_pf) begin
                     pf_state <= PF_NEED;
                  end else begin
                     user_r_mem_32_data <= ram_rdata;
                     pf_state           <= PF_VALID;
                  end
               end
               PF_VALID: begin
                  if (user_r_mem_32_rden | user_mem_32_addr_update | wr_hit_pf)
                     pf_state <= PF_NEED;
               end
               default: pf_state <= PF_IDLE;
            endcase
         end
      end
   end

`ifdef XMEM_ARB_STATS_EN
   always_ff @(posedge bus_clk or negedge trn_reset_n) begin
      if (!trn_reset_n) begin
         stat_host_grants <= '0;
         stat_loc_grants  <= '0;
         stat_conflicts   <= '0;
      end else if (stat_clr) begin
         stat_host_grants <= '0;
         stat_loc_grants  <= '0;
         stat_conflicts   <= '0;
      end else begin
         if (gnt_host) stat_host_grants <= sat_inc16(stat_host_grants);
         if (gnt_loc)  stat_loc_grants  <= sat_inc16(stat_loc_grants);
         if (arb_en & host_req & loc_req) stat_conflicts <= sat_inc16(stat_conflicts);
      end
   end
`endif

endmodule

// File: tb/tb_xmem_arbiter.sv
// Directed self-checking bench for xmem_arbiter; statistics checks compile in with XMEM_ARB_STATS_EN.
module tb_xmem_arbiter;
   import xmem_arb_pkg::*;

   logic        bus_clk;
   logic        trn_reset_n;
   logic        user_w_mem_32_wren;
   logic [31:0] user_w_mem_32_data;
   logic        user_w_mem_32_full;
   logic        user_w_mem_32_open;
   logic        user_r_mem_32_rden;
   logic [31:0] user_r_mem_32_data;
   logic        user_r_mem_32_empty;
   logic        user_r_mem_32_eof;
   logic        user_r_mem_32_open;
   logic [4:0]  user_mem_32_addr;
   logic        user_mem_32_addr_update;
   logic        loc_req;
   logic        loc_we;
   logic [4:0]  loc_addr;
   logic [31:0] loc_wdata;
   logic        loc_gnt;
   logic        loc_rvalid;
   logic [31:0] loc_rdata;
   pf_state_t   pf_dbg;
`ifdef XMEM_ARB_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_host_grants;
   logic [15:0] stat_loc_grants;
   logic [15:0] stat_conflicts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   xmem_arbiter dut (
      .bus_clk                 (bus_clk),
      .trn_reset_n             (trn_reset_n),
      .user_w_mem_32_wren      (user_w_mem_32_wren),
      .user_w_mem_32_data      (user_w_mem_32_data),
      .user_w_mem_32_full      (user_w_mem_32_full),
      .user_w_mem_32_open      (user_w_mem_32_open),
      .user_r_mem_32_rden      (user_r_mem_32_rden),
      .user_r_mem_32_data      (user_r_mem_32_data),
      .user_r_mem_32_empty     (user_r_mem_32_empty),
      .user_r_mem_32_eof       (user_r_mem_32_eof),
      .user_r_mem_32_open      (user_r_mem_32_open),
      .user_mem_32_addr        (user_mem_32_addr),
      .user_mem_32_addr_update (user_mem_32_addr_update),
      .loc_req                 (loc_req),
      .loc_we                  (loc_we),
      .loc_addr                (loc_addr),
      .loc_wdata               (loc_wdata),
      .loc_gnt                 (loc_gnt),
      .loc_rvalid              (loc_rvalid),
      .loc_rdata               (loc_rdata),
      .pf_state_dbg            (pf_dbg)
`ifdef XMEM_ARB_STATS_EN
      ,
      .stat_clr                (stat_clr),
      .stat_host_grants        (stat_host_grants),
      .stat_loc_grants         (stat_loc_grants),
      .stat_conflicts          (stat_conflicts)
`endif
   );

   // clock / reset
   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // host must never strobe wren while full is high
   always @(negedge bus_clk) begin
      if (trn_reset_n && user_w_mem_32_wren && user_w_mem_32_full) begin
         n_fail++;
         $display("FAIL wren_while_full: wren=1 full=1 at %0t", $time);
      end
   end

   // driver: one local transaction, bounded wait for the grant
   task automatic loc_op(input logic we, input logic [4:0] a, input logic [31:0] wd,
                         output logic ok, output logic rv, output logic [31:0] rd);
      ok = 1'b0; rv = 1'b0; rd = '0;
      loc_req = 1'b1; loc_we = we; loc_addr = a; loc_wdata = wd;
      for (int n = 0; n < 8; n++) begin
         @(negedge bus_clk);
         if (loc_gnt) begin ok = 1'b1; break; end
         @(posedge bus_clk); #1;
      end
      @(posedge bus_clk); #1;
      loc_req = 1'b0;
      if (ok) begin
         @(negedge bus_clk);
         rv = loc_rvalid; rd = loc_rdata;
         @(posedge bus_clk); #1;
      end
   endtask

   task automatic test_reset();
      trn_reset_n = 1'b0;
      user_w_mem_32_wren = 0; user_w_mem_32_data = '0; user_w_mem_32_open = 1;
      user_r_mem_32_rden = 0; user_r_mem_32_open = 0;
      user_mem_32_addr = '0; user_mem_32_addr_update = 0;
      loc_req = 0; loc_we = 0; loc_addr = '0; loc_wdata = '0;
`ifdef XMEM_ARB_STATS_EN
      stat_clr = 0;
`endif
      #3;
      n_checks++; if (user_w_mem_32_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", user_w_mem_32_full); end
      n_checks++; if (user_r_mem_32_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", user_r_mem_32_empty); end
      n_checks++; if (user_r_mem_32_eof !== 1'b0) begin n_fail++; $display("FAIL rst_eof: got %b want 0", user_r_mem_32_eof); end
      n_checks++; if (user_r_mem_32_data !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", user_r_mem_32_data); end
      n_checks++; if (loc_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", loc_gnt); end
      n_checks++; if (loc_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", loc_rvalid); end
      n_checks++; if (loc_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_loc_rdata: got %h want 0", loc_rdata); end
      n_checks++; if (pf_dbg !== PF_IDLE) begin n_fail++; $display("FAIL rst_pf: got %0d want %0d", pf_dbg, PF_IDLE); end
      @(negedge bus_clk); trn_reset_n = 1'b1;
      @(posedge bus_clk); #1;
      @(posedge bus_clk); #1;
   endtask

   task automatic test_open();
      logic ok, rv; logic [31:0] rd;
      loc_op(1'b1, 5'd0, 32'h1234_5678, ok, rv, rd);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL open_preload_gnt: got %b want 1", ok); end
      user_mem_32_addr = 5'd0; user_r_mem_32_open = 1'b1;
      @(negedge bus_clk);
      n_checks++; if (user_r_mem_32_empty !== 1'b1) begin n_fail++; $display("FAIL open_empty_c0: got %b want 1", user_r_mem_32_empty); end
      for (int c = 1; c <= 3; c++) begin
         @(posedge bus_clk); #1;
         @(negedge bus_clk);
         n_checks++; if (user_r_mem_32_empty !== (c < 3)) begin n_fail++; $display("FAIL open_empty_c%0d: got %b want %b", c, user_r_mem_32_empty, (c < 3)); end
         n_checks++; if (user_w_mem_32_full !== 1'b0) begin n_fail++; $display("FAIL open_full_c%0d: got %b want 0", c, user_w_mem_32_full); end
         if (c == 2) begin
            n_checks++; if (pf_dbg !== PF_BUSY) begin n_fail++; $display("FAIL open_pf_busy: got %0d want %0d", pf_dbg, PF_BUSY); end
         end
      end
      n_checks++; if (user_r_mem_32_data !== 32'h1234_5678) begin n_fail++; $display("FAIL open_data: got %h want 12345678", user_r_mem_32_data); end
      @(posedge bus_clk); #1;
   endtask

   task automatic test_host_burst();
      logic ok, rv; logic [31:0] rd;
      user_r_mem_32_open = 1'b0;
      for (int i = 0; i < 8; i++) begin
         user_mem_32_addr = 5'(i); user_w_mem_32_data = 32'hA0 + 32'(i); user_w_mem_32_wren = 1'b1;
         @(negedge bus_clk);
         n_checks++; if (user_w_mem_32_full !== 1'b0) begin n_fail++; $display("FAIL burst_full_%0d: got %b want 0", i, user_w_mem_32_full); end
         @(posedge bus_clk); #1;
      end
      user_w_mem_32_wren = 1'b0;
      @(posedge bus_clk); #1;
      for (int i = 0; i < 8; i++) begin
         loc_op(1'b0, 5'(i), '0, ok, rv, rd);
         n_checks++; if (ok !== 1'b1 || rv !== 1'b1) begin n_fail++; $display("FAIL burst_rd_hs_%0d: gnt %b rvalid %b want 1 1", i, ok, rv); end
         n_checks++; if (rd !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL burst_rd_%0d: got %h want %h", i, rd, 32'hA0 + 32'(i)); end
      end
   endtask

   task automatic test_contention();
      logic [8:0] wren_t = 9'b000101011;  // bit k = wren in cycle k
      logic [8:0] gnt_t  = 9'b101010101;
      logic [8:0] full_t = 9'b001010100;
      int idx = 0;
`ifdef XMEM_ARB_STATS_EN
      stat_clr = 1'b1; @(posedge bus_clk); #1; stat_clr = 1'b0;
`endif
      loc_req = 1'b1; loc_we = 1'b0; loc_addr = 5'd3;
      for (int k = 0; k < 9; k++) begin
         user_w_mem_32_wren = wren_t[k];
         user_mem_32_addr   = 5'(8 + idx);
         user_w_mem_32_data = 32'hB0 + 32'(idx);
         if (wren_t[k]) idx++;
         @(negedge bus_clk);
         n_checks++; if (loc_gnt !== gnt_t[k]) begin n_fail++; $display("FAIL cont_gnt_%0d: got %b want %b", k, loc_gnt, gnt_t[k]); end
         n_checks++; if (user_w_mem_32_full !== full_t[k]) begin n_fail++; $display("FAIL cont_full_%0d: got %b want %b", k, user_w_mem_32_full, full_t[k]); end
         n_checks++; if (loc_rvalid !== (k > 0 && gnt_t[k-1])) begin n_fail++; $display("FAIL cont_rvalid_%0d: got %b want %b", k, loc_rvalid, (k > 0 && gnt_t[k-1])); end
         if (loc_rvalid === 1'b1) begin
            n_checks++; if (loc_rdata !== 32'hA3) begin n_fail++; $display("FAIL cont_rdata_%0d: got %h want a3", k, loc_rdata); end
         end
         @(posedge bus_clk); #1;
      end
      user_w_mem_32_wren = 1'b0; loc_req = 1'b0;
      @(negedge bus_clk);
      n_checks++; if (loc_rvalid !== 1'b1 || loc_rdata !== 32'hA3) begin n_fail++; $display("FAIL cont_last_rd: rvalid %b data %h want 1 a3", loc_rvalid, loc_rdata); end
`ifdef XMEM_ARB_STATS_EN
      n_checks++; if (stat_conflicts !== 16'd7) begin n_fail++; $display("FAIL stat_conflicts: got %0d want 7", stat_conflicts); end
      n_checks++; if (stat_host_grants !== 16'd4) begin n_fail++; $display("FAIL stat_host: got %0d want 4", stat_host_grants); end
      n_checks++; if (stat_loc_grants !== 16'd5) begin n_fail++; $display("FAIL stat_loc: got %0d want 5", stat_loc_grants); end
`endif
      @(posedge bus_clk); #1;
   endtask

   task automatic test_coherency();
      logic ok, rv; logic [31:0] rd;
      loc_op(1'b1, 5'd5, 32'h55, ok, rv, rd);
      user_mem_32_addr = 5'd5; user_r_mem_32_open = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge bus_clk); if (!user_r_mem_32_empty) break;
         @(posedge bus_clk); #1;
      end
      n_checks++; if (user_r_mem_32_empty !== 1'b0 || user_r_mem_32_data !== 32'h55) begin n_fail++; $display("FAIL coh_first: empty %b data %h want 0 55", user_r_mem_32_empty, user_r_mem_32_data); end
      @(posedge bus_clk); #1;
      loc_req = 1'b1; loc_we = 1'b1; loc_addr = 5'd5; loc_wdata = 32'h99;
      @(negedge bus_clk);
      n_checks++; if (loc_gnt !== 1'b1 || user_r_mem_32_empty !== 1'b0) begin n_fail++; $display("FAIL coh_wr_gnt: gnt %b empty %b want 1 0", loc_gnt, user_r_mem_32_empty); end
      @(posedge bus_clk); #1; loc_req = 1'b0;
      @(negedge bus_clk);
      n_checks++; if (user_r_mem_32_empty !== 1'b1) begin n_fail++; $display("FAIL coh_empty_rise: got %b want 1", user_r_mem_32_empty); end
      @(posedge bus_clk); #1;
      for (int n = 0; n < 10; n++) begin
         @(negedge bus_clk); if (!user_r_mem_32_empty) break;
         @(posedge bus_clk); #1;
      end
      n_checks++; if (user_r_mem_32_empty !== 1'b0 || user_r_mem_32_data !== 32'h99) begin n_fail++; $display("FAIL coh_refetch: empty %b data %h want 0 99", user_r_mem_32_empty, user_r_mem_32_data); end
      @(posedge bus_clk); #1;
   endtask

   task automatic test_stale_fetch();
      user_mem_32_addr = 5'd4; user_mem_32_addr_update = 1'b1;
      @(posedge bus_clk); #1; user_mem_32_addr_update = 1'b0;
      @(negedge bus_clk);
      n_checks++; if (pf_dbg !== PF_NEED || user_r_mem_32_empty !== 1'b1) begin n_fail++; $display("FAIL stale_need4: pf %0d empty %b want %0d 1", pf_dbg, user_r_mem_32_empty, PF_NEED); end
      @(posedge bus_clk); #1;
      user_mem_32_addr = 5'd9; user_mem_32_addr_update = 1'b1;
      @(negedge bus_clk);
      n_checks++; if (pf_dbg !== PF_BUSY) begin n_fail++; $display("FAIL stale_busy4: pf %0d want %0d", pf_dbg, PF_BUSY); end
      @(posedge bus_clk); #1; user_mem_32_addr_update = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge bus_clk);
         n_checks++; if (user_r_mem_32_empty !== 1'b1 || user_r_mem_32_data !== 32'h99) begin n_fail++; $display("FAIL stale_hold_%0d: empty %b data %h want 1 99", c, user_r_mem_32_empty, user_r_mem_32_data); end
         @(posedge bus_clk); #1;
      end
      @(negedge bus_clk);
      n_checks++; if (user_r_mem_32_empty !== 1'b0 || user_r_mem_32_data !== 32'hB1) begin n_fail++; $display("FAIL stale_data9: empty %b data %h want 0 b1", user_r_mem_32_empty, user_r_mem_32_data); end
      @(posedge bus_clk); #1;
   endtask

   task automatic test_reset_midstream();
      logic ok, rv; logic [31:0] rd;
      loc_op(1'b1, 5'd12, 32'h0C0C, ok, rv, rd);
      user_mem_32_addr = 5'd12; user_w_mem_32_data = 32'hDEAD; user_w_mem_32_wren = 1'b1;
      @(posedge bus_clk); #1;
      user_w_mem_32_wren = 1'b0;
      #1 trn_reset_n = 1'b0;
      #1;
      n_checks++; if (user_r_mem_32_empty !== 1'b1 || user_w_mem_32_full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: empty %b full %b want 1 0", user_r_mem_32_empty, user_w_mem_32_full); end
      n_checks++; if (user_r_mem_32_data !== 32'h0 || loc_rdata !== 32'h0 || loc_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_data: rdata %h loc_rdata %h rvalid %b want 0 0 0", user_r_mem_32_data, loc_rdata, loc_rvalid); end
      n_checks++; if (pf_dbg !== PF_IDLE) begin n_fail++; $display("FAIL mid_rst_pf: got %0d want %0d", pf_dbg, PF_IDLE); end
      user_r_mem_32_open = 1'b0;
      @(negedge bus_clk); trn_reset_n = 1'b1;
      @(posedge bus_clk); #1;
      @(posedge bus_clk); #1;
      loc_op(1'b0, 5'd12, '0, ok, rv, rd);
      n_checks++; if (ok !== 1'b1 || rv !== 1'b1 || rd !== 32'h0C0C) begin n_fail++; $display("FAIL mid_rst_ram12: gnt %b rvalid %b data %h want 1 1 0c0c", ok, rv, rd); end
   endtask

   initial begin
      test_reset();
      test_open();
      test_host_burst();
      test_contention();
      test_coherency();
      test_stale_fetch();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
